// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-requester arbiter.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  // Expand a requester index into a one-hot grant vector.
  function automatic logic [N_REQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] vec;
    vec = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
    return vec;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational winner selection: rotate the request vector so the
// search start lands on bit 7, take the highest set bit, rotate back.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] start,
  input  logic             mode,
  output logic [IDX_W-1:0] win,
  output logic             any
);

  logic [IDX_W-1:0] eff_start_s;
  logic [IDX_W-1:0] shift_s;
  logic [N_REQ-1:0] rot_s;
  logic [IDX_W-1:0] pos_s;

  // Rotate so that req[start] maps to rot[7]; lower rot bits continue the descending order.
  always_comb begin
    eff_start_s = mode ? start : 3'd7;
    shift_s     = eff_start_s + 3'd1;
    for (int j = 0; j < N_REQ; j++) begin
      rot_s[j] = req[3'(j) + shift_s];
    end
  end

  // Highest-index priority encode of the rotated vector, then undo the rotation.
  always_comb begin
    pos_s = 3'd0;
    for (int j = 0; j < N_REQ; j++) begin
      if (rot_s[j]) begin
        pos_s = 3'(j);
      end else begin
        pos_s = pos_s;
      end
    end
    win = pos_s + shift_s;
    any = |req;
  end

endmodule

// File: rtl/arb8_rr_ctrl.sv
// 8-requester arbiter: fixed-priority or round-robin winner selection,
// grant held until release, request drop or hold timeout, then one dead cycle.
module arb8_rr_ctrl
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  // A zero MAX_HOLD turns the hold limit off entirely.
  localparam logic             TIMEOUT_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(MAX_HOLD - 1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0] last_id_q, last_id_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_id_q, gnt_id_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q, timeout_d;

  logic [IDX_W-1:0] pick_start_s;
  logic [IDX_W-1:0] pick_win_s;
  logic             pick_any_s;

  // Round-robin search begins just below the previous winner (wraps 0 -> 7).
  assign pick_start_s = last_id_q - 3'd1;

  rr_pick8 u_pick (
    .req   (req),
    .start (pick_start_s),
    .mode  (mode),
    .win   (pick_win_s),
    .any   (pick_any_s)
  );

  // Next-state and next-output logic for the IDLE/GRANT/GAP sequence.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    last_id_d   = last_id_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && pick_any_s) begin
          state_d     = GRANT;
          hold_cnt_d  = {CNT_W{1'b0}};
          last_id_d   = pick_win_s;
          gnt_d       = onehot8(pick_win_s);
          gnt_id_d    = pick_win_s;
          gnt_valid_d = 1'b1;
        end else begin
          gnt_d       = {N_REQ{1'b0}};
          gnt_valid_d = 1'b0;
        end
      end
      GRANT: begin
        hold_cnt_d = hold_cnt_q + CNT_W'(1);
        // Release order matters: en, done and request drop never flag a timeout.
        if (!en || done || !req[gnt_id_q]) begin
          state_d     = GAP;
          gnt_d       = {N_REQ{1'b0}};
          gnt_valid_d = 1'b0;
        end else if (TIMEOUT_EN && (hold_cnt_q == HOLD_LAST)) begin
          state_d     = GAP;
          gnt_d       = {N_REQ{1'b0}};
          gnt_valid_d = 1'b0;
          timeout_d   = 1'b1;
        end else begin
          state_d = GRANT;
        end
      end
      GAP: begin
        state_d     = IDLE;
        gnt_d       = {N_REQ{1'b0}};
        gnt_valid_d = 1'b0;
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = {N_REQ{1'b0}};
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_cnt_q  <= {CNT_W{1'b0}};
      last_id_q   <= 3'd0;
      gnt_q       <= {N_REQ{1'b0}};
      gnt_id_q    <= 3'd0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      last_id_q   <= last_id_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule
